// File: rtl/placement_search_ctrl_if.sv
// Bus between the placement search sequencer and its neighbours: the game
// FSM (start/results), the placement generator and the board analyzer.
interface placement_search_ctrl_if #(
   parameter int SCORE_W = 64
);
   // game FSM side
   logic                      start;
   logic                      busy;
   logic                      done;
   logic                      found;
   logic [1:0]                best_rot;
   logic [3:0]                best_col;
   logic signed [SCORE_W-1:0] best_score;
   logic                      timeout_err;
   // placement generator side
   logic                      cand_req;
   logic [1:0]                cand_rot;
   logic [3:0]                cand_col;
   logic                      cand_ack;
   logic                      cand_legal;
   // board analyzer side
   logic                      req_score;
   logic                      recv_score;
   logic signed [SCORE_W-1:0] score;

   modport slave (
      input  start, cand_ack, cand_legal, recv_score, score,
      output busy, done, found, best_rot, best_col, best_score, timeout_err,
             cand_req, cand_rot, cand_col, req_score
   );

   modport master (
      output start, cand_ack, cand_legal, recv_score, score,
      input  busy, done, found, best_rot, best_col, best_score, timeout_err,
             cand_req, cand_rot, cand_col, req_score
   );
endinterface

// File: rtl/placement_search_ctrl.sv
// Exhaustive placement search sequencer: walks every (rotation, column)
// candidate, asks the generator for its board, scores legal boards with the
// analyzer and keeps the lowest score. Results publish only in DONE.
module placement_search_ctrl #(
   parameter int NUM_ROT = 4,
   parameter int NUM_COL = 10,
   parameter int SCORE_W = 64,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst_n,
   placement_search_ctrl_if.slave bus
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic signed [SCORE_W-1:0] SCORE_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0]    ROT_LAST  = 2'(NUM_ROT - 1);
   localparam logic [3:0]    COL_LAST  = 4'(NUM_COL - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_SCORE_REQ, S_SCORE_WAIT, S_NEXT, S_DONE
   } state_t;

   state_t                    r_state, w_next;
   logic                      w_tmo;
   logic                      w_better;
   logic                      w_last_cand;

   logic [CW-1:0]             r_wait_cnt;
   logic [1:0]                r_cand_rot;
   logic [3:0]                r_cand_col;
   logic signed [SCORE_W-1:0] r_cur_score;
   logic                      r_cur_valid;
   logic signed [SCORE_W-1:0] r_best;
   logic [1:0]                r_best_rot;
   logic [3:0]                r_best_col;
   logic                      r_found;

   logic signed [SCORE_W-1:0] r_out_score;
   logic [1:0]                r_out_rot;
   logic [3:0]                r_out_col;
   logic                      r_out_found;
   logic                      r_timeout_err;

   // strict compare so ties keep the earliest candidate in search order
   assign w_better    = r_cur_valid && (r_cur_score < r_best);
   assign w_last_cand = (r_cand_col == COL_LAST) && (r_cand_rot == ROT_LAST);

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state logic; w_tmo flags a handshake abandoned on the wait limit
   always_comb begin
      w_next = r_state;
      w_tmo  = 1'b0;
      case (r_state)
         S_IDLE:       if (bus.start) w_next = S_GEN;
         S_GEN: begin
            if (bus.cand_ack)
               w_next = bus.cand_legal ? S_SCORE_REQ : S_NEXT;
            else if (r_wait_cnt == WAIT_LAST) begin
               w_next = S_DONE;
               w_tmo  = 1'b1;
            end
         end
         S_SCORE_REQ:  w_next = S_SCORE_WAIT;
         S_SCORE_WAIT: begin
            if (bus.recv_score)
               w_next = S_NEXT;
            else if (r_wait_cnt == WAIT_LAST) begin
               w_next = S_DONE;
               w_tmo  = 1'b1;
            end
         end
         S_NEXT:       w_next = w_last_cand ? S_DONE : S_GEN;
         S_DONE:       w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   // wait counter: both waiting states are always entered from a non-waiting
   // state, so clearing outside them gives a fresh count on every entry
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_wait_cnt <= '0;
      else if (r_state == S_GEN || r_state == S_SCORE_WAIT)
         r_wait_cnt <= r_wait_cnt + 1'b1;
      else
         r_wait_cnt <= '0;
   end

   // candidate walk, score capture and running best
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cand_rot  <= '0;
         r_cand_col  <= '0;
         r_cur_score <= '0;
         r_cur_valid <= 1'b0;
         r_best      <= SCORE_MAX;
         r_best_rot  <= '0;
         r_best_col  <= '0;
         r_found     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_cand_rot  <= '0;
                  r_cand_col  <= '0;
                  r_cur_valid <= 1'b0;
                  r_best      <= SCORE_MAX;
                  r_best_rot  <= '0;
                  r_best_col  <= '0;
                  r_found     <= 1'b0;
               end
            end
            S_SCORE_WAIT: begin
               if (bus.recv_score) begin
                  r_cur_score <= bus.score;
                  r_cur_valid <= 1'b1;
               end
            end
            S_NEXT: begin
               if (w_better) begin
                  r_best     <= r_cur_score;
                  r_best_rot <= r_cand_rot;
                  r_best_col <= r_cand_col;
                  r_found    <= 1'b1;
               end
               r_cur_valid <= 1'b0;
               if (r_cand_col == COL_LAST) begin
                  r_cand_col <= '0;
                  r_cand_rot <= r_cand_rot + 1'b1;
               end else begin
                  r_cand_col <= r_cand_col + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // published results: held between searches, refreshed only on DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_score   <= SCORE_MAX;
         r_out_rot     <= '0;
         r_out_col     <= '0;
         r_out_found   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.start) r_timeout_err <= 1'b0;
         if (w_tmo)                          r_timeout_err <= 1'b1;
         if (r_state == S_DONE) begin
            r_out_score <= r_best;
            r_out_rot   <= r_best_rot;
            r_out_col   <= r_best_col;
            r_out_found <= r_found;
         end
      end
   end

   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = (r_state == S_DONE);
   assign bus.cand_req    = (r_state == S_GEN);
   assign bus.req_score   = (r_state == S_SCORE_REQ);
   assign bus.cand_rot    = r_cand_rot;
   assign bus.cand_col    = r_cand_col;
   assign bus.found       = r_out_found;
   assign bus.best_rot    = r_out_rot;
   assign bus.best_col    = r_out_col;
   assign bus.best_score  = r_out_score;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_placement_search_ctrl.sv
// Bench for placement_search_ctrl: a responder process plays generator and
// analyzer; a table of search scenarios is run with expected results queued
// at start and popped when done pulses; plus a mid-search reset sequence.
module tb_placement_search_ctrl;
   localparam int     NR   = 4;
   localparam int     NC   = 10;
   localparam int     SW   = 64;
   localparam int     TMO  = 255;
   localparam longint SMAX = 64'sh7FFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   placement_search_ctrl_if #(.SCORE_W(SW)) bus();

   placement_search_ctrl #(
      .NUM_ROT(NR), .NUM_COL(NC), .SCORE_W(SW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      int     scen;       // 0 descending, 1 tie, 2 all illegal, 3 mixed
      int     ack_dly;    // extra GEN cycles before the generator acks
      bit     stray;      // recv_score pulses during GEN
      bit     busy_start; // start held high whenever busy
      bit     mute;       // analyzer never answers
      int     exp_done;   // cycles from start to done
      bit     exp_found;
      int     exp_rot;
      int     exp_col;
      longint exp_score;
      bit     exp_tmo;
      int     exp_req;    // number of req_score cycles
   } vec_t;

   vec_t vecs[6];
   vec_t sb_q[$];

   int n_chk = 0;
   int n_err = 0;

   // scenario controls (written by main only)
   int cur_scen = 0;
   int cur_ack_dly = 0;
   bit cur_stray = 0;
   bit cur_mute = 0;

   // responder state (written by responder only)
   int req_cnt = 0;
   int gen_wait = 0;
   int an_pipe = 0;
   int an_rot = 0;
   int an_col = 0;

   function automatic bit legal_of(int s, int r, int c);
      if (s == 2) return 1'b0;
      if (s == 3) return ((r + c) % 3) != 0;
      return 1'b1;
   endfunction

   function automatic longint score_of(int s, int r, int c);
      case (s)
         0: return longint'(1000 - (r * 10 + c));
         1: return ((r == 1 && c == 4) || (r == 2 && c == 7)) ? -64'sd20 : 64'sd500;
         3: begin
            if (r == 0 && c == 1) return 64'sd4611686018427387904;
            if (r == 3 && c == 8) return -64'sd1099511627776;
            return longint'((r * 37 + c * 11) % 50 - 25);
         end
         default: return 0;
      endcase
   endfunction

   // reference: scan candidates in search order, keep strictly lower scores
   task automatic model(input int s, output bit f, output int br, output int bc,
                        output longint bs, output int nleg);
      f = 0; br = 0; bc = 0; bs = SMAX; nleg = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (legal_of(s, r, c)) begin
               nleg++;
               if (score_of(s, r, c) < bs) begin
                  bs = score_of(s, r, c); br = r; bc = c; f = 1;
               end
            end
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // generator and analyzer models; inputs change at negedge, held a cycle
   initial begin
      bus.cand_ack   = 1'b0;
      bus.cand_legal = 1'b0;
      bus.recv_score = 1'b0;
      bus.score      = '0;
      forever begin
         @(negedge clk);
         bus.cand_ack   = 1'b0;
         bus.recv_score = 1'b0;
         if (!rst_n) begin
            an_pipe  = 0;
            gen_wait = 0;
         end else begin
            // analyzer: request seen, one calculate cycle, then the strobe
            if (an_pipe == 2) begin
               bus.recv_score = 1'b1;
               bus.score      = score_of(cur_scen, an_rot, an_col);
               an_pipe        = 0;
            end else if (an_pipe == 1) begin
               an_pipe = 2;
            end
            if (bus.req_score) begin
               req_cnt++;
               if (!cur_mute) begin
                  an_pipe = 1;
                  an_rot  = int'(bus.cand_rot);
                  an_col  = int'(bus.cand_col);
               end
            end
            // generator
            if (bus.cand_req) begin
               if (gen_wait >= cur_ack_dly) begin
                  bus.cand_ack   = 1'b1;
                  bus.cand_legal = legal_of(cur_scen, int'(bus.cand_rot), int'(bus.cand_col));
                  gen_wait       = 0;
               end else begin
                  gen_wait++;
                  if (cur_stray) begin
                     bus.recv_score = 1'b1;
                     bus.score      = -64'sd9999;
                  end
               end
            end else begin
               gen_wait = 0;
            end
         end
      end
   end

   task automatic chk_reset(input string p);
      chk({p, ".busy"},     longint'(bus.busy), 0);
      chk({p, ".done"},     longint'(bus.done), 0);
      chk({p, ".found"},    longint'(bus.found), 0);
      chk({p, ".rot"},      longint'(bus.best_rot), 0);
      chk({p, ".col"},      longint'(bus.best_col), 0);
      chk({p, ".score"},    bus.best_score, SMAX);
      chk({p, ".tmo"},      longint'(bus.timeout_err), 0);
      chk({p, ".cand_req"}, longint'(bus.cand_req), 0);
      chk({p, ".req"},      longint'(bus.req_score), 0);
   endtask

   task automatic run_vec(input string p, input vec_t v);
      int   n;
      bit   seen;
      int   req0;
      vec_t e;
      cur_scen    = v.scen;
      cur_ack_dly = v.ack_dly;
      cur_stray   = v.stray;
      cur_mute    = v.mute;
      req0        = req_cnt;
      sb_q.push_back(v);
      @(negedge clk);
      bus.start = 1'b1;
      n = 0;
      seen = 0;
      while (!seen && n < 600) begin
         @(negedge clk);
         n++;
         bus.start = v.busy_start && bus.busy;
         if (bus.done) seen = 1;
      end
      e = sb_q.pop_front();
      chk({p, ".done_cycle"}, seen ? n : -1, e.exp_done);
      @(negedge clk);
      bus.start = 1'b0;
      chk({p, ".idle_after"}, longint'(bus.busy), 0);
      chk({p, ".found"},      longint'(bus.found), longint'(e.exp_found));
      chk({p, ".rot"},        longint'(bus.best_rot), e.exp_rot);
      chk({p, ".col"},        longint'(bus.best_col), e.exp_col);
      chk({p, ".score"},      bus.best_score, e.exp_score);
      chk({p, ".tmo"},        longint'(bus.timeout_err), longint'(e.exp_tmo));
      chk({p, ".req_cnt"},    req_cnt - req0, e.exp_req);
   endtask

   initial begin
      bit     f;
      int     br, bc, nl;
      longint bs;

      //          scen dly str bst mute done  fnd rot col score           tmo req
      vecs[0] = '{0,   0,  0,  0,  0,   201,  1,  3,  9,  961,            0,  40};
      vecs[1] = '{1,   0,  0,  0,  0,   201,  1,  1,  4,  -20,            0,  40};
      vecs[2] = '{2,   0,  0,  0,  0,   81,   0,  0,  0,  SMAX,           0,  0};
      model(3, f, br, bc, bs, nl);
      vecs[3] = '{3,   0,  0,  0,  0,   nl*5 + (NR*NC - nl)*2 + 1,
                                              f,  br, bc, bs,             0,  nl};
      vecs[4] = '{0,   2,  1,  1,  0,   281,  1,  3,  9,  961,            0,  40};
      vecs[5] = '{0,   0,  0,  0,  1,   TMO + 3, 0, 0, 0, SMAX,           1,  1};

      bus.start = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         run_vec($sformatf("v%0d", i), vecs[i]);

      // abort mid-SCORE_WAIT of the first candidate, then a clean search
      cur_scen = 1; cur_ack_dly = 0; cur_stray = 0; cur_mute = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset("midrst");
      rst_n = 1'b1;
      @(negedge clk);
      run_vec("after_rst", vecs[1]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
